// File: rtl/bsg_pkg.sv
// bsg_pkg: register map, CONTROL bit indices, FSM states and Gray helper
// for bsg_tx_core (parity symbol enabled by BSG_PARITY_EN).
package bsg_pkg;

  localparam logic [1:0] REG_CONTROL = 2'd0;
  localparam logic [1:0] REG_DATA    = 2'd1;
  localparam logic [1:0] REG_DIV     = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTL_TXEN    = 0;
  localparam int CTL_INTMSK  = 1;
  localparam int CTL_INTFLAG = 2;
  localparam int CTL_BUSY    = 3;
  localparam int CTL_OVF     = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    PAR,
    END
  } bsg_state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] w);
    return w ^ (w >> 1);
  endfunction

endpackage

// File: rtl/bsg_tx_core_if.sv
// bsg_tx_core_if: peripheral register bus between a host and bsg_tx_core.
// Read data is combinational from REG_ADDR.
interface bsg_tx_core_if #(
  parameter int DATA_W = 8
);

  logic              REG_WE;
  logic              REG_RE;
  logic [1:0]        REG_ADDR;
  logic [DATA_W-1:0] REG_WDATA;
  logic [DATA_W-1:0] REG_RDATA;

  modport master (
    output REG_WE,
    output REG_RE,
    output REG_ADDR,
    output REG_WDATA,
    input  REG_RDATA
  );

  modport slave (
    input  REG_WE,
    input  REG_RE,
    input  REG_ADDR,
    input  REG_WDATA,
    output REG_RDATA
  );

endinterface

// File: rtl/bsg_sym_fifo.sv
// bsg_sym_fifo: synchronous word FIFO with occupancy count.
// A push while full is taken only when a pop happens in the same cycle.
module bsg_sym_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= wdata;
    end
  end

endmodule

// File: rtl/bsg_tx_core.sv
// bsg_tx_core: register-programmed, FIFO-buffered Gray symbol transmitter.
// Define BSG_PARITY_EN to append a parity symbol after each word.
module bsg_tx_core #(
  parameter int DATA_W = 8,
  parameter int SYM_W  = 2,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 8,
  parameter int OUT_W  = 8
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST_N,
  bsg_tx_core_if.slave     bus,
  output logic [OUT_W-1:0] OUT,
  output logic             BSG_INT
);

  import bsg_pkg::*;

  localparam int NSYM = DATA_W / SYM_W;
  localparam int SCW  = $clog2(NSYM + 1);
  localparam int CW   = $clog2(DEPTH) + 1;

  bsg_state_t        state_q, state_d;
  logic              txen_q, txen_d;
  logic              intmsk_q, intmsk_d;
  logic              intflag_q, intflag_d;
  logic              ovf_q, ovf_d;
  logic              int_q, int_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [SCW-1:0]    sym_q, sym_d;
  logic [OUT_W-1:0]  out_q, out_d;
`ifdef BSG_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              ctl_we, data_we, div_we;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata, gray, wd, rdata;
  logic [CW-1:0]     fifo_count;
  logic              done_set, ovf_set;
  logic              unused_re;

  function automatic logic [OUT_W-1:0] lvl(input logic [SYM_W-1:0] s);
    return OUT_W'(s) << (OUT_W - SYM_W);
  endfunction

  assign wd        = bus.REG_WDATA;
  assign unused_re = bus.REG_RE;
  assign ctl_we    = bus.REG_WE & (bus.REG_ADDR == REG_CONTROL);
  assign data_we   = bus.REG_WE & (bus.REG_ADDR == REG_DATA);
  assign div_we    = bus.REG_WE & (bus.REG_ADDR == REG_DIV);
  assign fifo_pop  = (state_q == LOAD);
  assign ovf_set   = data_we & fifo_full & ~fifo_pop;
  assign gray      = DATA_W'(bin2gray(32'(fifo_rdata)));

  bsg_sym_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (SYS_CLK),
    .rst_n (SYS_RST_N),
    .push  (data_we),
    .pop   (fifo_pop),
    .wdata (wd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    shreg_d  = shreg_q;
    sym_d    = sym_q;
    out_d    = out_q;
    done_set = 1'b0;
`ifdef BSG_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        out_d = '0;
        if (txen_q & ~fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        shreg_d = gray;
        sym_d   = '0;
        baud_d  = div_q;
        out_d   = lvl(gray[DATA_W-1 -: SYM_W]);
        state_d = SHIFT;
`ifdef BSG_PARITY_EN
        par_d   = ^gray;
`endif
      end
      SHIFT: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          // divider reloads per symbol so DIV writes land on a symbol start
          baud_d  = div_q;
          shreg_d = shreg_q << SYM_W;
          sym_d   = sym_q + 1'b1;
          if (sym_q == SCW'(NSYM - 1)) begin
`ifdef BSG_PARITY_EN
            out_d   = lvl(SYM_W'(par_q));
            state_d = PAR;
`else
            out_d   = '0;
            state_d = END;
`endif
          end else begin
            out_d = lvl(shreg_d[DATA_W-1 -: SYM_W]);
          end
        end
      end
`ifdef BSG_PARITY_EN
      PAR: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          out_d   = '0;
          state_d = END;
        end
      end
`endif
      END: begin
        out_d = '0;
        if (txen_q & ~fifo_empty) begin
          state_d = LOAD;
        end else begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: begin
        out_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    txen_d   = txen_q;
    intmsk_d = intmsk_q;
    div_d    = div_q;
    if (ctl_we) begin
      txen_d   = wd[CTL_TXEN];
      intmsk_d = wd[CTL_INTMSK];
    end
    if (div_we) div_d = wd[DIV_W-1:0];
    // a set in the same cycle as a write-1-clear wins
    intflag_d = done_set | (intflag_q & ~(ctl_we & wd[CTL_INTFLAG]));
    ovf_d     = ovf_set | (ovf_q & ~(ctl_we & wd[CTL_OVF]));
    int_d     = intflag_q & intmsk_q;
  end

  always_comb begin
    rdata = '0;
    unique case (bus.REG_ADDR)
      REG_CONTROL: begin
        rdata[CTL_TXEN]    = txen_q;
        rdata[CTL_INTMSK]  = intmsk_q;
        rdata[CTL_INTFLAG] = intflag_q;
        rdata[CTL_BUSY]    = (state_q != IDLE);
        rdata[CTL_OVF]     = ovf_q;
      end
      REG_DATA:   rdata = DATA_W'(fifo_count);
      REG_DIV:    rdata = DATA_W'(div_q);
      REG_STATUS: rdata = DATA_W'({fifo_count, fifo_full, fifo_empty});
      default:    rdata = '0;
    endcase
  end

  assign bus.REG_RDATA = rdata;
  assign OUT           = out_q;
  assign BSG_INT       = int_q;

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q   <= IDLE;
      txen_q    <= 1'b0;
      intmsk_q  <= 1'b0;
      intflag_q <= 1'b0;
      ovf_q     <= 1'b0;
      int_q     <= 1'b0;
      div_q     <= '0;
      baud_q    <= '0;
      shreg_q   <= '0;
      sym_q     <= '0;
      out_q     <= '0;
`ifdef BSG_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      txen_q    <= txen_d;
      intmsk_q  <= intmsk_d;
      intflag_q <= intflag_d;
      ovf_q     <= ovf_d;
      int_q     <= int_d;
      div_q     <= div_d;
      baud_q    <= baud_d;
      shreg_q   <= shreg_d;
      sym_q     <= sym_d;
      out_q     <= out_d;
`ifdef BSG_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
